// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and multi-cycle control FSM
// for a simple register/ALU datapath.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in[15:0], load      instruction word and IR capture enable (WAIT only)
//   s, w                start request / idle-and-ready indication
//   readnum, writenum   register file read / write indices
//   vsel                writeback select (00=C, 01=PC, 10=sximm8, 11=mdata)
//   loada, loadb, loadc A/B/C register load strobes
//   loads, write        status register load, register file write enable
//   asel, bsel          A forced to zero / B taken from sximm5
//   shift, ALUop        shifter and ALU operation codes
//   sximm5, sximm8      sign-extended immediates from the IR
module cpu_controller #(
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_CMPS,
        S_WREG
    } state_t;

    state_t      state, next_state;
    logic [15:0] ir;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_movi, is_movr, is_alu, is_cmp, is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);

    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign shift  = (is_alu || is_movr) ? sh : 2'b00;
    assign ALUop  = is_alu ? op : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= IR_RESET;
        end else begin
            state <= next_state;
            if ((state == S_WAIT) && load)
                ir <= in;
        end
    end

    always_comb begin
        next_state = state;
        w          = 1'b0;
        readnum    = 3'b000;
        writenum   = 3'b000;
        vsel       = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        write      = 1'b0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi)
                    next_state = S_WIMM;
                else if (is_movr || is_mvn)
                    next_state = S_GETB;
                else if (is_alu)
                    next_state = S_GETA;
                else
                    next_state = S_WAIT;
            end
            S_WIMM: begin
                writenum   = rn;
                vsel       = 2'b10;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            S_GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GETB;
            end
            S_GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = is_cmp ? S_CMPS : S_EXEC;
            end
            S_EXEC: begin
                loadc      = 1'b1;
                asel       = is_movr || is_mvn;
                next_state = S_WREG;
            end
            S_CMPS: begin
                loads      = 1'b1;
                next_state = S_WAIT;
            end
            S_WREG: begin
                writenum   = rd;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase

        // Reset takes effect at the next edge; until then keep every load and
        // write strobe quiet so an aborted instruction leaves no side effects.
        if (reset) begin
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
            write = 1'b0;
        end
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control end of the datapath interface: holds the 16-bit instruction register (IR), decodes it, and runs the multi-cycle FSM.
- Generates every datapath control input: readnum, writenum, vsel, loada, loadb, asel, bsel, loadc, loads, write, shift, ALUop, sximm5, sximm8.
- Handshakes with the outside world through s/w.
- Sits between instruction source and datapath; datapath C/Z_out are not consumed.

Parameters:
IR_RESET, 16'h0000, IR value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in  input  16  instruction word
load  input  1  IR capture enable
s  input  1  start execution of IR
w  output  1  1 = idle in WAIT, ready for s
readnum  output  3  regfile read index
writenum  output  3  regfile write index
vsel  output  2  writeback select: 00=C, 01=PC, 10=sximm8, 11=mdata
loada  output  1  A register load
loadb  output  1  B register load
asel  output  1  1 = A operand forced to 0
bsel  output  1  1 = B operand is sximm5
loadc  output  1  C register load
loads  output  1  status register load
write  output  1  regfile write enable
shift  output  2  shifter op
ALUop  output  2  ALU op
sximm5  output  16  sign-extended IR[4:0]
sximm8  output  16  sign-extended IR[7:0]

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - MOV Rn,#imm8: 110/10
  - MOV Rd,Rm{,sh}: 110/00
  - ADD: 101/00
  - CMP: 101/01
  - AND: 101/10
  - MVN: 101/11
  - Anything else is a NOP.
- IR loads `in` at the edge where load=1, only while the FSM is in WAIT. load outside WAIT is ignored. With load=1 and s=1 in the same WAIT cycle, DECODE uses the newly loaded IR.
- sximm5 and sximm8 are combinational from IR.
- shift = sh for opcode 101 or 110/00, else 00.
- ALUop = op for opcode 101, 00 for MOV reg.
- Moore FSM states, with all unlisted strobes = 0 and vsel/asel/bsel = 0 unless listed:
  - WAIT: w=1. s=1 -> DECODE, else stay.
  - DECODE: branch as follows.
    - 110/10 -> WIMM
    - 110/00 or 101/11 -> GETB
    - other 101 -> GETA
    - else -> WAIT
  - WIMM: writenum=Rn, vsel=10, write=1 -> WAIT.
  - GETA: readnum=Rn, loada=1 -> GETB.
  - GETB: readnum=Rm, loadb=1. Next state is CMPS for CMP, else EXEC.
  - EXEC: loadc=1. asel=1 for MOV reg/MVN, else 0. bsel=0 -> WREG.
  - CMPS: asel=0, bsel=0, loads=1, loadc=0 -> WAIT.
  - WREG: writenum=Rd, vsel=00, write=1 -> WAIT.
- readnum/writenum outside the listed states = 000.
- s is ignored outside WAIT.
- w=0 durations from the s-accept edge:
  - MOV imm: 2 cycles
  - MOV reg/MVN: 4 cycles
  - CMP: 4 cycles
  - ADD/AND: 5 cycles
  - NOP: 1 cycle
- Reset:
  - While reset=1, loada, loadb, loadc, loads and write are forced 0 combinationally in any state.
  - At the next edge: state=WAIT, IR=IR_RESET.
  - First cycle after reset release: w=1, all strobes 0, sximm5=sximm8=0.
  - Reset mid-instruction aborts it with no further writes.
- Exactly one of write/loads is asserted per completed instruction; NOP asserts neither.

Test Plan:
- Reset, then load in=16'hD007 (MOV R0,#7) with s=1 -> DECODE, then WIMM with write=1, writenum=0, vsel=10, sximm8=16'h0007; w=0 exactly 2 cycles, then w=1.
- in=16'hD1FE (MOV R1,#-2) -> WIMM with sximm8=16'hFFFE, writenum=1.
- in=16'hA148 (ADD R2,R1,R0,LSL#1):
  - GETA: readnum=1, loada=1
  - GETB: readnum=0, loadb=1
  - EXEC: asel=0, bsel=0, ALUop=00, shift=01, loadc=1
  - WREG: writenum=2, vsel=00, write=1
  - w=0 for 5 cycles
- in=16'hA900 (CMP R1,R0) -> loads=1 for exactly one cycle, write never 1, loadc never 1, w=0 for 4 cycles.
- in=16'hB860 (MVN R3,R0) -> GETB readnum=0; EXEC asel=1, ALUop=11; WREG writenum=3.
- in=16'h0000 with s=1 -> w=0 one cycle, no strobes.
- ADD in flight: raise reset during GETB -> loadb=0 that cycle, next cycle w=1, write never asserted.
- load=1 with new word during ADD execution -> IR unchanged.
